// File: rtl/relu_backward_if.sv
// relu_backward_if
// Bundles the start/done handshake and the three wide vector buses of the
// ReLU backward block.
//   enable        : level start request, held by the master until done is seen
//   forward_input : forward-pass ReLU inputs x, element i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   grad_in       : upstream gradient, same packing
//   grad_out      : downstream gradient, same packing
//   done          : result valid / operation complete
// Modports: master drives the request and vectors, slave (the block) returns
// grad_out and done.
interface relu_backward_if #(
    parameter int WIDTH      = 128,
    parameter int DATA_WIDTH = 16
);
    logic                        enable;
    logic [WIDTH*DATA_WIDTH-1:0] forward_input;
    logic [WIDTH*DATA_WIDTH-1:0] grad_in;
    logic [WIDTH*DATA_WIDTH-1:0] grad_out;
    logic                        done;

    modport master (
        output enable,
        output forward_input,
        output grad_in,
        input  grad_out,
        input  done
    );

    modport slave (
        input  enable,
        input  forward_input,
        input  grad_in,
        output grad_out,
        output done
    );
endinterface

// File: rtl/relu_backward.sv
// relu_backward
// Backward pass of a ReLU activation over a full vector:
//   grad_out[i] = grad_in[i] when x[i] > 0, otherwise 0.
// The vector is processed LANES elements per clock, lowest group first.
// Optional build macro LEAKY_GRAD_EN: for x <= 0 the gradient becomes
//   grad_in >>> LEAK_SHIFT instead of 0. Timing is identical in both builds.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high reset
//   bus       : relu_backward_if.slave (enable, forward_input, grad_in,
//               grad_out, done)
//   state_dbg : current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: the requester raises enable and holds it; the edge that sees
// enable=1 in IDLE captures both input vectors. done rises exactly
// WIDTH/LANES edges later and stays high (grad_out stable) until the first
// edge that sees enable=0, which returns the block to IDLE. A started run
// always completes regardless of enable.
module relu_backward #(
    parameter int WIDTH      = 128,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8,
    parameter int LEAK_SHIFT = 4
) (
    input  logic              clk,
    input  logic              reset,
    relu_backward_if.slave    bus,
    output logic [1:0]        state_dbg
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH % LANES != 0) begin : g_bad_lanes
        $error("relu_backward: WIDTH must be a multiple of LANES");
    end
    if (LEAK_SHIFT < 0 || LEAK_SHIFT >= DATA_WIDTH) begin : g_bad_shift
        $error("relu_backward: LEAK_SHIFT out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]                  index;
    logic [WIDTH-1:0][DATA_WIDTH-1:0]  x_snap;
    logic [WIDTH-1:0][DATA_WIDTH-1:0]  g_snap;
    logic [WIDTH-1:0][DATA_WIDTH-1:0]  out_vec;
    logic [WIDTH-1:0][DATA_WIDTH-1:0]  out_next;
    logic                              last_group;

    assign last_group = (index == IDX_W'(WIDTH - LANES));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.enable) state_next = BUSY;
            BUSY:    if (last_group) state_next = DONE;
            DONE:    if (!bus.enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: done is a pure function of the state, so reset clears it
    // immediately along with the state register.
    assign bus.done     = (state == DONE);
    assign state_dbg    = state;
    assign bus.grad_out = out_vec;

    // Gradient for the current group, merged into the held output vector.
    always_comb begin
        logic [IDX_W-1:0] elem;
        elem     = '0;
        out_next = out_vec;
        for (int l = 0; l < LANES; l++) begin
            elem = index + IDX_W'(l);
            if ($signed(x_snap[elem]) > 0) begin
                out_next[elem] = g_snap[elem];
            end else begin
`ifdef LEAKY_GRAD_EN
                out_next[elem] = DATA_WIDTH'($signed(g_snap[elem]) >>> LEAK_SHIFT);
`else
                out_next[elem] = '0;
`endif
            end
        end
    end

    // Datapath: snapshot on start, one group per edge while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index   <= '0;
            x_snap  <= '0;
            g_snap  <= '0;
            out_vec <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        x_snap <= bus.forward_input;
                        g_snap <= bus.grad_in;
                        index  <= '0;
                    end
                end
                BUSY: begin
                    out_vec <= out_next;
                    index   <= index + IDX_W'(LANES);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_relu_backward.sv
module tb_relu_backward;
    localparam int W      = 128;
    localparam int DW     = 16;
    localparam int L      = 8;
    localparam int LS     = 4;
    localparam int VW     = W * DW;
    localparam int GROUPS = W / L;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    relu_backward_if #(.WIDTH(W), .DATA_WIDTH(DW)) bus ();
    logic [1:0] state_dbg;

    relu_backward #(.WIDTH(W), .DATA_WIDTH(DW), .LANES(L), .LEAK_SHIFT(LS)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] prev_exp = '0;
    bit  tracking  = 1'b0;
    int  start_cyc = 0;

    // Reference: element rule applied to whole vectors.
    function automatic logic [VW-1:0] model(input logic [VW-1:0] x, input logic [VW-1:0] g);
        logic [VW-1:0] r;
        logic signed [DW-1:0] xe, ge;
        r = '0;
        for (int i = 0; i < W; i++) begin
            xe = x[i*DW +: DW];
            ge = g[i*DW +: DW];
            if (xe > 0) r[i*DW +: DW] = ge;
`ifdef LEAKY_GRAD_EN
            else r[i*DW +: DW] = ge >>> LS;
`else
            else r[i*DW +: DW] = '0;
`endif
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec(input bit sprinkle_zero);
        logic [VW-1:0] r;
        logic [31:0] rv;
        for (int i = 0; i < W; i++) begin
            rv = $urandom;
            if (sprinkle_zero && $urandom_range(0, 7) == 0) rv = '0;
            r[i*DW +: DW] = rv[DW-1:0];
        end
        return r;
    endfunction

    task automatic check_vec(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        int first;
        first = -1;
        total++;
        for (int i = 0; i < W; i++)
            if (first < 0 && got[i*DW +: DW] !== exp[i*DW +: DW]) first = i;
        if (first >= 0) begin
            bad++;
            $display("FAIL %s t=%0t elem=%0d got=%h exp=%h", name, $time, first,
                     got[first*DW +: DW], exp[first*DW +: DW]);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    task automatic check_elem(input string name, input int i, input logic [DW-1:0] exp);
        check_val(name, 32'(bus.grad_out[i*DW +: DW]), 32'(exp));
    endtask

    // ---------------- compare process ----------------
    // k edges after the start edge, groups 0..k-1 carry the new result and
    // the rest still hold the previous one; done is high from k = GROUPS.
    always @(negedge clk) begin
        if (tracking && !reset) begin
            int k, n;
            logic [VW-1:0] e;
            k = cyc - start_cyc;
            n = (k > GROUPS) ? GROUPS : k;
            for (int i = 0; i < W; i++)
                e[i*DW +: DW] = (i < n * L) ? exp_q[$][i*DW +: DW] : prev_exp[i*DW +: DW];
            check_vec("progress_data", bus.grad_out, e);
            check_val("progress_done", 32'(bus.done), 32'(k >= GROUPS));
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a negedge; returns just after a negedge with enable low
    // and the block back in IDLE.
    task automatic run(input logic [VW-1:0] x, input logic [VW-1:0] g,
                       input int hold, input bit mutate);
        bit seen;
        bus.forward_input = x;
        bus.grad_in       = g;
        bus.enable        = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        prev_exp  = (exp_q.size() > 0) ? exp_q[$] : prev_exp;
        exp_q.push_back(model(x, g));
        tracking  = 1'b1;
        if (mutate) begin
            @(posedge clk); #1;
            bus.forward_input = rand_vec(1'b1);
            bus.grad_in       = rand_vec(1'b0);
        end
        seen = 1'b0;
        for (int t = 0; t < 3 * GROUPS && !seen; t++) begin
            @(negedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout t=%0t got=0 exp=1", $time);
        end else begin
            check_val("done_latency", 32'(cyc - start_cyc), 32'(GROUPS));
        end
        repeat (hold) @(negedge clk);
        #1;
        bus.enable = 1'b0;
        tracking   = 1'b0;
        @(negedge clk); #1;
        check_val("done_fall", 32'(bus.done), 32'd0);
        check_vec("hold_data", bus.grad_out, exp_q[$]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tracking = 1'b0;
        bus.enable = 1'b0;
        #1;
        check_vec("reset_data", bus.grad_out, '0);
        check_val("reset_done", 32'(bus.done), 32'd0);
        check_val("reset_state", 32'(state_dbg), 32'd0);
        exp_q.delete();
        prev_exp = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [VW-1:0] x, g;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.forward_input = '0;
        bus.grad_in = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Alternating signs, constant gradient
        for (int i = 0; i < W; i++) begin
            x[i*DW +: DW] = (i % 2 == 0) ? 16'h0200 : 16'hFE00;
            g[i*DW +: DW] = 16'h0100;
        end
        run(x, g, 0, 1'b0);
        check_elem("alt_even0", 0, 16'h0100);
        check_elem("alt_even126", 126, 16'h0100);
`ifdef LEAKY_GRAD_EN
        check_elem("alt_odd1", 1, 16'h0010);
        check_elem("alt_odd127", 127, 16'h0010);
`else
        check_elem("alt_odd1", 1, 16'h0000);
        check_elem("alt_odd127", 127, 16'h0000);
`endif

        // Boundary values
        x = rand_vec(1'b1);
        for (int i = 0; i < W; i++) g[i*DW +: DW] = 16'hFF80;
        x[0*DW +: DW] = 16'h0000;
        x[1*DW +: DW] = 16'hF000;
        x[2*DW +: DW] = 16'h1000;
        x[3*DW +: DW] = 16'h8000;
        x[4*DW +: DW] = 16'h7FFF;
        run(x, g, 0, 1'b0);
`ifdef LEAKY_GRAD_EN
        check_elem("bnd_zero", 0, 16'hFFF8);
        check_elem("bnd_neg", 1, 16'hFFF8);
        check_elem("bnd_min", 3, 16'hFFF8);
`else
        check_elem("bnd_zero", 0, 16'h0000);
        check_elem("bnd_neg", 1, 16'h0000);
        check_elem("bnd_min", 3, 16'h0000);
`endif
        check_elem("bnd_pos", 2, 16'hFF80);
        check_elem("bnd_max", 4, 16'hFF80);

        // Snapshot isolation and done held while enable stays high
        run(rand_vec(1'b1), rand_vec(1'b0), 5, 1'b1);

        // Async reset in the middle of a run
        bus.forward_input = rand_vec(1'b1);
        bus.grad_in       = rand_vec(1'b0);
        bus.enable        = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        prev_exp  = exp_q[$];
        exp_q.push_back(model(bus.forward_input, bus.grad_in));
        tracking = 1'b1;
        while (cyc - start_cyc < 7) @(negedge clk);
        #1;
        do_reset();
        run(rand_vec(1'b1), rand_vec(1'b0), 0, 1'b0);

        // Back-to-back random runs
        for (int r = 0; r < 6; r++)
            run(rand_vec(1'b1), rand_vec(1'b0), $urandom_range(0, 2), 1'b0);

`ifdef LEAKY_GRAD_EN
        x = rand_vec(1'b1);
        g = rand_vec(1'b0);
        x[0*DW +: DW] = 16'hFE00; g[0*DW +: DW] = 16'h0100;
        x[1*DW +: DW] = 16'hFE00; g[1*DW +: DW] = 16'hFF00;
        x[2*DW +: DW] = 16'h0200; g[2*DW +: DW] = 16'h1234;
        run(x, g, 0, 1'b0);
        check_elem("leak_pos_grad", 0, 16'h0010);
        check_elem("leak_neg_grad", 1, 16'hFFF0);
        check_elem("leak_pass", 2, 16'h1234);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
